// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with clear engine and pending scoreboard.
// Optional write-through bypass enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                sysclk,
  input  logic                sysreset_n,
  input  logic                we,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic [NRD*$clog2(NREGS)-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_pend,
  input  logic                res_we,
  input  logic [$clog2(NREGS)-1:0] res_addr,
  input  logic                clr_req,
  output logic                ready
);

  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   clr_ptr;
  logic [AW-1:0]   clr_ptr_nx;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nx;
  logic [XLEN-1:0] regs [NREGS];

  logic run;
  logic wr_ok;
  logic res_ok;

  assign run   = (state == RUN);
  assign ready = run;

  // A write or reservation only lands in RUN and never alongside a clear request.
  assign wr_ok  = run & we & ~clr_req
                & ~(ZR && (rd_addr == '0));
  assign res_ok = run & res_we & ~clr_req
                & ~(ZR && (res_addr == '0));

  // State, clear pointer and pending bits; reset restarts the clear.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      pend    <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
      pend    <= pend_nx;
    end
  end

  // Next state: sweep the array while clearing; reservation beats write on pend.
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    pend_nx    = pend;
    unique case (state)
      CLEAR: begin
        clr_ptr_nx = clr_ptr + AW'(1);
        if (clr_ptr == AW'(NREGS - 1)) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
          pend_nx    = '0;
        end else begin
          if (wr_ok) begin
            pend_nx[rd_addr] = 1'b0;
          end
          if (res_ok) begin
            pend_nx[res_addr] = 1'b1;
          end
        end
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  // Storage array: zeroed one entry per cycle by the clear engine, no async reset.
  always_ff @(posedge sysclk) begin
    if (state == CLEAR) begin
      regs[clr_ptr] <= '0;
    end else if (wr_ok) begin
      regs[rd_addr] <= rd_data;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          zhit;
      logic          byp;
      logic          res_hit;

      assign ra      = rs_addr[k*AW +: AW];
      assign zhit    = ZR && (ra == '0);
      assign byp     = BYP && wr_ok && (ra == rd_addr);
      assign res_hit = res_ok && (res_addr == ra);

      assign rs_data[k*XLEN +: XLEN] =
        (!run || zhit) ? '0 :
        byp            ? rd_data :
                         regs[ra];

      assign rs_pend[k] =
        (!run || zhit) ? 1'b0 :
        byp            ? res_hit :
                         pend[ra];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// Expected read results are queued at drive time and popped on sampling.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                sysclk = 1'b0;
  logic                sysreset_n = 1'b0;
  logic                we = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic [XLEN-1:0]     rd_data = '0;
  logic [NRD*AW-1:0]   rs_addr = '0;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_pend;
  logic                res_we = 1'b0;
  logic [AW-1:0]       res_addr = '0;
  logic                clr_req = 1'b0;
  logic                ready;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_pend(rs_pend),
    .res_we(res_we), .res_addr(res_addr),
    .clr_req(clr_req), .ready(ready)
  );

  always #5 sysclk = ~sysclk;

  int n_run  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] mdl [NREGS];
  logic            mp  [NREGS];

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [63:0] mexp(int a);
    if (a == 0) return 64'd0;
    return {31'b0, mp[a], mdl[a]};
  endfunction

  task automatic push(string tag, logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    for (int k = 0; k < NRD; k++) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
        return;
      end
      e = exp_q.pop_front();
      chk(e.tag, {31'b0, rs_pend[k], rs_data[k*XLEN +: XLEN]}, e.val);
    end
  endtask

  task automatic rdx(int a0, int a1, logic [63:0] e0, logic [63:0] e1,
                     string tag);
    rs_addr = {AW'(a1), AW'(a0)};
    push($sformatf("%s_p0_x%0d", tag, a0), e0);
    push($sformatf("%s_p1_x%0d", tag, a1), e1);
    #1;
    pop_cmp();
  endtask

  task automatic rd2(int a0, int a1, string tag);
    rdx(a0, a1, mexp(a0), mexp(a1), tag);
  endtask

  task automatic wr(int a, logic [XLEN-1:0] d);
    we = 1'b1; rd_addr = AW'(a); rd_data = d;
    tick();
    we = 1'b0;
    if (a != 0) begin
      mdl[a] = d;
      mp[a]  = 1'b0;
    end
  endtask

  task automatic rsv(int a);
    res_we = 1'b1; res_addr = AW'(a);
    tick();
    res_we = 1'b0;
    if (a != 0) mp[a] = 1'b1;
  endtask

  task automatic wr_rsv(int a, logic [XLEN-1:0] d);
    we = 1'b1; rd_addr = AW'(a); rd_data = d;
    res_we = 1'b1; res_addr = AW'(a);
    tick();
    we = 1'b0; res_we = 1'b0;
    if (a != 0) begin
      mdl[a] = d;
      mp[a]  = 1'b1;
    end
  endtask

  task automatic wait_ready(string tag, int exp_n);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mdl[i] = '0;
      mp[i]  = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    rdx(5, 6, 64'd0, 64'd0, "rst_rd");

    sysreset_n = 1'b1;
    wait_ready("rst_lat", NREGS);
    for (int i = 0; i < NREGS; i++) rd2(i, NREGS - 1 - i, "init");

    wr(5, 32'hDEADBEEF);
    rd2(5, 5, "x5");
    wr(0, 32'h1234);
    rd2(0, 5, "x0");

    rsv(7);
    rd2(7, 5, "rsv7");
    rsv(0);
    rd2(0, 7, "rsv0");
    wr(7, 32'hA5A5A5A5);
    rd2(7, 7, "wr7");
    wr_rsv(9, 32'h11);
    rd2(9, 9, "wrrsv9");

    wr(3, 32'h77);
    we = 1'b1; rd_addr = AW'(3); rd_data = 32'h55;
    rs_addr = {AW'(5), AW'(3)};
`ifdef REGFILE_MP_BYPASS_EN
    push("byp_same_x3", 64'h55);
`else
    push("byp_same_x3", mexp(3));
`endif
    push("byp_same_x5", mexp(5));
    #1;
    pop_cmp();
    tick();
    we = 1'b0;
    mdl[3] = 32'h55;
    rd2(3, 3, "byp_next");

    for (int i = 1; i < NREGS; i++)
      wr(i, (32'(i) * 32'h01010101) ^ 32'h5A5A0000);
    rsv(12);
    for (int i = 1; i < NREGS; i++) rd2(i, NREGS - i, "fill");

    clr_req = 1'b1;
    we = 1'b1; rd_addr = AW'(4); rd_data = 32'hFFFF_FFFF;
    tick();
    clr_req = 1'b0;
    res_we = 1'b1; res_addr = AW'(13);
    chk("clr_ready0", 64'(ready), 64'd0);
    rdx(31, 12, 64'd0, 64'd0, "clr_rd");
    wait_ready("clr_lat", NREGS);
    we = 1'b0;
    res_we = 1'b0;
    model_clear();
    for (int i = 0; i < NREGS; i++) rd2(i, NREGS - 1 - i, "post_clr");

    wr(2, 32'hCAFE0002);
    wr(30, 32'hCAFE001E);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    sysreset_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(ready), 64'd0);
    tick();
    tick();
    sysreset_n = 1'b1;
    wait_ready("mrst_lat", NREGS);
    model_clear();
    rd2(2, 30, "mrst_rd");
    rd2(31, 1, "mrst_rd");

    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
